// File: rtl/pktsink_pkg.sv
// Shared types and constants for the 10GbE MAC packet sink.
// The descriptor struct is the FIFO word: 16-bit length plus 4 error flags.
package pktsink_pkg;

   typedef enum logic [0:0] {
      StIdle  = 1'b0,
      StInPkt = 1'b1
   } state_e;

   localparam int unsigned ErrTrunc    = 0;
   localparam int unsigned ErrOversize = 1;
   localparam int unsigned ErrMac      = 2;
   localparam int unsigned ErrRunt     = 3;

   localparam int unsigned LenWidth  = 16;
   localparam int unsigned ErrWidth  = 4;
   localparam int unsigned BeatBytes = 8;
   localparam int unsigned RuntLen   = 14;

   typedef struct packed {
      logic [LenWidth-1:0] len;
      logic [ErrWidth-1:0] err;
   } desc_t;

   // Length accumulation clamps at all-ones instead of wrapping.
   function automatic logic [LenWidth-1:0] len_sat_add(input logic [LenWidth-1:0] len,
                                                       input logic [3:0]          inc);
      logic [LenWidth:0] sum;
      sum = {1'b0, len} + {{(LenWidth - 3){1'b0}}, inc};
      return sum[LenWidth] ? {LenWidth{1'b1}} : sum[LenWidth-1:0];
   endfunction

endpackage

// File: rtl/pktsink_desc_fifo.sv
// Synchronous descriptor FIFO with full/empty flags and show-ahead read data.
// Depth must be a power of two; pointers carry one extra wrap bit.
module pktsink_desc_fifo #(
   parameter int unsigned Width = 20,
   parameter int unsigned Depth = 4
) (
   input  logic             clk_in,
   input  logic             reset,
   input  logic             push,
   input  logic [Width-1:0] push_data,
   input  logic             pop,
   output logic [Width-1:0] pop_data,
   output logic             full,
   output logic             empty
);

   localparam int unsigned AddrW = (Depth > 1) ? $clog2(Depth) : 1;

   logic [Width-1:0] mem_q [Depth];
   logic [AddrW:0]   wr_ptr_q;
   logic [AddrW:0]   rd_ptr_q;
   logic             do_push;
   logic             do_pop;

   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]) &&
                  (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);

   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   always_ff @(posedge clk_in or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (do_push) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         if (do_pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_in) begin
      if (do_push) begin
         mem_q[wr_ptr_q[AddrW-1:0]] <= push_data;
      end
   end

   assign pop_data = mem_q[rd_ptr_q[AddrW-1:0]];

endmodule

// File: rtl/pktsink_10gbmac.sv
// Avalon-ST packet sink for a 10GbE MAC: measures each packet, flags errors and
// queues one length/error descriptor per packet, with packet and drop counters.
module pktsink_10gbmac
   import pktsink_pkg::*;
#(
   parameter int unsigned MAX_LEN    = 9600,
   parameter int unsigned DESC_DEPTH = 4
) (
   input  logic        clk_in,
   input  logic        reset,
   input  logic        hold,
   input  logic [63:0] asi_in_data,
   input  logic        asi_in_valid,
   output logic        asi_in_ready,
   input  logic        asi_in_sop,
   input  logic        asi_in_eop,
   input  logic [2:0]  asi_in_empty,
   input  logic [5:0]  asi_in_error,
   output logic        desc_valid,
   input  logic        desc_ready,
   output logic [15:0] desc_len,
   output logic [3:0]  desc_err,
   output logic [7:0]  pktcount,
   output logic [7:0]  dropcount
);

   localparam logic [31:0] MaxLenW = 32'(MAX_LEN);

   state_e        state_q, state_d;
   logic [15:0]   len_q, len_d;
   logic          mac_q, mac_d;
   logic          run_q;
   logic [7:0]    pkt_cnt_q;
   logic [7:0]    drop_cnt_q;

   logic          accept;
   logic          beat_err;
   logic [3:0]    last_bytes;
   logic          push;
   logic          trunc;
   logic          drop;
   logic [15:0]   push_len;
   logic          push_mac;
   desc_t         push_desc;
   desc_t         pop_desc;
   logic          fifo_full;
   logic          fifo_empty;
   logic          pop;
   logic          unused_data;

   assign unused_data = ^asi_in_data;

   // run_q keeps ready low through reset and rises on the first edge after it.
   assign asi_in_ready = run_q && !hold && !fifo_full;
   assign accept       = asi_in_valid && asi_in_ready;
   assign beat_err     = |asi_in_error;
   assign last_bytes   = 4'(BeatBytes) - {1'b0, asi_in_empty};

   always_ff @(posedge clk_in or posedge reset) begin
      if (reset) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (accept) begin
         unique case (state_q)
            StIdle: begin
               if (asi_in_sop && !asi_in_eop) begin
                  state_d = StInPkt;
               end
            end
            StInPkt: begin
               if (asi_in_eop) begin
                  state_d = StIdle;
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   always_comb begin
      len_d    = len_q;
      mac_d    = mac_q;
      push     = 1'b0;
      trunc    = 1'b0;
      drop     = 1'b0;
      push_len = len_q;
      push_mac = mac_q;
      if (accept) begin
         unique case (state_q)
            StIdle: begin
               if (!asi_in_sop) begin
                  drop = 1'b1;
               end else if (asi_in_eop) begin
                  push     = 1'b1;
                  push_len = {12'd0, last_bytes};
                  push_mac = beat_err;
               end else begin
                  len_d = 16'(BeatBytes);
                  mac_d = beat_err;
               end
            end
            StInPkt: begin
               if (asi_in_sop) begin
                  // Close the open packet as truncated before handling the new sop.
                  push  = 1'b1;
                  trunc = 1'b1;
                  if (asi_in_eop) begin
                     drop  = 1'b1;
                     len_d = '0;
                     mac_d = 1'b0;
                  end else begin
                     len_d = 16'(BeatBytes);
                     mac_d = beat_err;
                  end
               end else if (asi_in_eop) begin
                  push     = 1'b1;
                  push_len = len_sat_add(len_q, last_bytes);
                  push_mac = mac_q | beat_err;
                  len_d    = '0;
                  mac_d    = 1'b0;
               end else begin
                  len_d = len_sat_add(len_q, 4'(BeatBytes));
                  mac_d = mac_q | beat_err;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      push_desc                  = '0;
      push_desc.len              = push_len;
      push_desc.err[ErrTrunc]    = trunc;
      push_desc.err[ErrOversize] = ({16'd0, push_len} > MaxLenW);
      push_desc.err[ErrMac]      = push_mac;
      push_desc.err[ErrRunt]     = (push_len < 16'(RuntLen));
   end

   always_ff @(posedge clk_in or posedge reset) begin
      if (reset) begin
         len_q      <= '0;
         mac_q      <= 1'b0;
         run_q      <= 1'b0;
         pkt_cnt_q  <= '0;
         drop_cnt_q <= '0;
      end else begin
         len_q <= len_d;
         mac_q <= mac_d;
         run_q <= 1'b1;
         if (push) begin
            pkt_cnt_q <= pkt_cnt_q + 8'd1;
         end
         if (drop && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_q <= drop_cnt_q + 8'd1;
         end
      end
   end

   pktsink_desc_fifo #(
      .Width ($bits(desc_t)),
      .Depth (DESC_DEPTH)
   ) u_desc_fifo (
      .clk_in    (clk_in),
      .reset     (reset),
      .push      (push),
      .push_data (push_desc),
      .pop       (pop),
      .pop_data  (pop_desc),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   assign desc_valid = !fifo_empty;
   assign pop        = desc_valid && desc_ready;
   assign desc_len   = pop_desc.len;
   assign desc_err   = pop_desc.err;
   assign pktcount   = pkt_cnt_q;
   assign dropcount  = drop_cnt_q;

endmodule
